// File: rtl/muldiv_if.sv
// Handshake and result bundle between the execute stage and muldiv_unit.
// The master drives the request; the slave returns status and the HI/LO registers.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, div_by_zero, illegal, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, div_by_zero, illegal, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO plus MTHI/MTLO.
// The divide datapath exists only when MULDIV_DIV_EN is defined; otherwise ops 2/3 flag illegal.
//   state | meaning
//   IDLE  | accept start; MTHI/MTLO and illegal ops complete here
//   CALC  | one shift-add or restoring-divide step per cycle, WIDTH steps
//   FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_q;
  logic               r_done;
  logic               r_illegal;
  logic               r_dbz;

  logic               w_busy;
  logic               w_in_calc;
  logic               w_in_fix;
  logic               w_accept;
  logic               w_op_mul;
  logic               w_op_div;
  logic               w_op_mt;
  logic               w_go;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_r;
  logic               r_div0;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_op_mul = (bus.op == 3'd0) || (bus.op == 3'd1);
  assign w_op_mt  = (bus.op == 3'd4) || (bus.op == 3'd5);
`ifdef MULDIV_DIV_EN
  assign w_op_div = (bus.op == 3'd2) || (bus.op == 3'd3);
`else
  assign w_op_div = 1'b0;
`endif
  assign w_go     = w_accept && (w_op_mul || w_op_div);
  assign w_signed = (bus.op == 3'd0) || (bus.op == 3'd2);
  assign w_mag_a  = (w_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign w_mag_b  = (w_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_ITER) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b0;
    w_in_calc = 1'b0;
    w_in_fix  = 1'b0;
    case (r_state)
      S_CALC: begin
        w_busy    = 1'b1;
        w_in_calc = 1'b1;
      end
      S_FIX: begin
        w_busy   = 1'b1;
        w_in_fix = 1'b1;
      end
      default: ;
    endcase
  end

  // Low half of r_acc holds the multiplier / shifting dividend, high half the partial product / remainder.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    w_div_ge   = (r_acc[2*WIDTH-1:WIDTH-1] >= {1'b0, r_opb});
    w_div_diff = r_acc[2*WIDTH-2:WIDTH-1] - r_opb;
    if (r_is_div) begin
      if (w_div_ge) w_acc_next = {w_div_diff, r_acc[WIDTH-2:0], 1'b1};
      else          w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo   = w_prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_lo = '1;
        w_fix_hi = r_a_raw;
      end else begin
        w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg_q   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_dbz     <= 1'b0;
      if (w_accept) begin
        if (w_go) begin
          r_cnt   <= '0;
          r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
          r_opb   <= w_mag_b;
          r_neg_q <= w_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
        end else if (w_op_mt) begin
          if (bus.op == 3'd4) r_hi <= bus.rs_val;
          else                r_lo <= bus.rs_val;
          r_done <= 1'b1;
        end else begin
          r_illegal <= 1'b1;
        end
      end else if (w_in_calc) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_in_fix) begin
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
        r_done <= 1'b1;
`ifdef MULDIV_DIV_EN
        r_dbz  <= r_is_div && r_div0;
`endif
      end
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a_raw  <= '0;
    end else if (w_go) begin
      r_is_div <= w_op_div;
      r_neg_r  <= w_signed && bus.rs_val[WIDTH-1];
      r_div0   <= (bus.rt_val == '0);
      r_a_raw  <= bus.rs_val;
    end
  end
`endif

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.illegal     = r_illegal;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; divide cases follow MULDIV_DIV_EN.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request before an edge; returns 1ns after the accepting edge with start dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_total++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else n_pass++;
    n_total++; if ({bus.busy, bus.done, bus.div_by_zero, bus.illegal} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.div_by_zero, bus.illegal});
    else n_pass++;
  endtask

  task automatic test_multu_max;
    int cyc; bit bok;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bok);
    n_total++; if (cyc !== 33) $display("FAIL multu_latency got %0d want 33", cyc); else n_pass++;
    n_total++; if (bok !== 1'b1) $display("FAIL multu_busy got %b want 1", bok); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL multu_busy_fall got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else n_pass++;
    n_total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.done !== 1'b0) $display("FAIL multu_done_width got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_mult_signed;
    int cyc; bit bok;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", bus.hi, bus.lo); else n_pass++;
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000)
      $display("FAIL mult_minmin got %h_%h want 40000000_00000000", bus.hi, bus.lo); else n_pass++;
    issue(3'd0, 32'h1234_5678, 32'h0000_0010);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_2345_6780)
      $display("FAIL mult_pos got %h_%h want 00000001_23456780", bus.hi, bus.lo); else n_pass++;
    issue(3'd1, 32'h8000_0000, 32'h0000_0003);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== 64'h0000_0001_8000_0000)
      $display("FAIL multu_big got %h_%h want 00000001_80000000", bus.hi, bus.lo); else n_pass++;
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_divide;
    int cyc; bit bok;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
      $display("FAIL div_neg7_2 got hi %h lo %h want ffffffff fffffffd", bus.hi, bus.lo); else n_pass++;
    n_total++; if (cyc !== 33) $display("FAIL div_latency got %0d want 33", cyc); else n_pass++;
    issue(3'd3, 32'd100, 32'd7);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14})
      $display("FAIL divu_100_7 got hi %h lo %h want 2 14", bus.hi, bus.lo); else n_pass++;
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== {32'd1, 32'hFFFF_FFFD})
      $display("FAIL div_7_neg2 got hi %h lo %h want 1 fffffffd", bus.hi, bus.lo); else n_pass++;
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== {32'd0, 32'h8000_0000})
      $display("FAIL div_overflow got hi %h lo %h want 0 80000000", bus.hi, bus.lo); else n_pass++;
  endtask

  task automatic test_div_by_zero;
    int cyc; bit bok;
    issue(3'd3, 32'h0000_1234, 32'd0);
    wait_done(cyc, bok);
    n_total++; if (cyc !== 33) $display("FAIL dbz_latency got %0d want 33", cyc); else n_pass++;
    n_total++; if ({bus.done, bus.div_by_zero} !== 2'b11)
      $display("FAIL dbz_pulse got %b want 11", {bus.done, bus.div_by_zero}); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {32'h0000_1234, 32'hFFFF_FFFF})
      $display("FAIL dbz_divu got hi %h lo %h want 1234 ffffffff", bus.hi, bus.lo); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL dbz_width got %b want 0", bus.div_by_zero); else n_pass++;
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc, bok);
    n_total++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF})
      $display("FAIL dbz_div got hi %h lo %h want fffffffb ffffffff", bus.hi, bus.lo); else n_pass++;
  endtask
`else
  task automatic test_div_disabled;
    logic [31:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    n_total++; if ({bus.illegal, bus.busy, bus.done} !== 3'b100)
      $display("FAIL div_off_flags got %b want 100", {bus.illegal, bus.busy, bus.done}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({bus.illegal, bus.busy} !== 2'b00)
      $display("FAIL div_off_after got %b want 00", {bus.illegal, bus.busy}); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {hi0, lo0})
      $display("FAIL div_off_hilo got %h_%h want %h_%h", bus.hi, bus.lo, hi0, lo0); else n_pass++;
    issue(3'd3, 32'd100, 32'd7);
    n_total++; if ({bus.illegal, bus.busy} !== 2'b10)
      $display("FAIL divu_off_flags got %b want 10", {bus.illegal, bus.busy}); else n_pass++;
  endtask
`endif

  task automatic test_mthi_mtlo;
    issue(3'd4, 32'h0000_CAFE, 32'h0);
    n_total++; if (bus.hi !== 32'h0000_CAFE) $display("FAIL mthi_val got %h want 0000cafe", bus.hi); else n_pass++;
    n_total++; if ({bus.done, bus.busy} !== 2'b10)
      $display("FAIL mthi_flags got %b want 10", {bus.done, bus.busy}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL mthi_after got %b want 00", {bus.done, bus.busy}); else n_pass++;
    issue(3'd5, 32'h0000_BEEF, 32'h0);
    n_total++; if ({bus.hi, bus.lo} !== {32'h0000_CAFE, 32'h0000_BEEF})
      $display("FAIL mtlo_val got %h_%h want 0000cafe_0000beef", bus.hi, bus.lo); else n_pass++;
  endtask

  task automatic test_reserved;
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    n_total++; if ({bus.illegal, bus.done, bus.busy} !== 3'b100)
      $display("FAIL reserved_flags got %b want 100", {bus.illegal, bus.done, bus.busy}); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {32'h0000_CAFE, 32'h0000_BEEF})
      $display("FAIL reserved_hilo got %h_%h want 0000cafe_0000beef", bus.hi, bus.lo); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.illegal !== 1'b0) $display("FAIL reserved_width got %b want 0", bus.illegal); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int cyc; bit bok;
    issue(3'd1, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 3'd4;
    bus.rs_val = 32'h0000_0999;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(cyc, bok);
    n_total++; if (cyc !== 23) $display("FAIL ignore_latency got %0d want 23", cyc); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {32'd0, 32'd15})
      $display("FAIL ignore_result got %h_%h want 00000000_0000000f", bus.hi, bus.lo); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc; bit bok;
    issue(3'd1, 32'd6, 32'd7);
    wait_done(cyc, bok);
    bus.start  = 1'b1;
    bus.op     = 3'd1;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    n_total++; if (bus.lo !== 32'd42) $display("FAIL b2b_first got %0d want 42", bus.lo); else n_pass++;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_total++; if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL b2b_accept got %b want 10", {bus.busy, bus.done}); else n_pass++;
    wait_done(cyc, bok);
    n_total++; if (cyc !== 33) $display("FAIL b2b_latency got %0d want 33", cyc); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== {32'd0, 32'd6})
      $display("FAIL b2b_second got %h_%h want 00000000_00000006", bus.hi, bus.lo); else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    bit saw_done;
    issue(3'd1, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if ({bus.busy, bus.done} !== 2'b00)
      $display("FAIL rstmid_flags got %b want 00", {bus.busy, bus.done}); else n_pass++;
    n_total++; if ({bus.hi, bus.lo} !== 64'h0)
      $display("FAIL rstmid_hilo got %h_%h want 0_0", bus.hi, bus.lo); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", saw_done); else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_multu_max();
    test_mult_signed();
`ifdef MULDIV_DIV_EN
    test_divide();
    test_div_by_zero();
`else
    test_div_disabled();
`endif
    test_mthi_mtlo();
    test_reserved();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits beside the ALU in the execution stage and takes the rs/rt register-file read values as operands. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are read by the write-back mux for MFHI/MFLO, and `busy` stalls fetch while an operation is in flight.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  operation in progress; upstream must hold the PC.
- `done`  out  1  one-cycle pulse on the cycle HI/LO become valid.
- `div_by_zero`  out  1  one-cycle pulse, coincident with `done`, for DIV/DIVU with `rt_val`=0.
- `illegal`  out  1  one-cycle pulse for a reserved or compiled-out op.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- Reset (async, `rst_n`=0):
  - state goes to IDLE.
  - `hi`, `lo`, `busy`, `done`, `div_by_zero` and `illegal` all go to 0.
  - any operation in flight is discarded.
- FSM states are IDLE, CALC and FIX.
- IDLE with `start`=1, op 0–3:
  - latch operands and op.
  - for signed ops, convert operands to magnitudes and record the result signs.
  - set the iteration counter to 0 and go to CALC.
- CALC runs WIDTH iterations, one per cycle, then goes to FIX.
  - Multiply: radix-2 shift-add producing a 2×WIDTH product.
  - Divide: restoring division, one quotient bit per cycle.
- FIX (one cycle):
  - apply sign correction.
  - write HI/LO, pulse `done`, return to IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Signed divide rules:
  - quotient is truncated toward zero.
  - remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
- Divide by zero:
  - LO=all-ones, HI=`rs_val`, `div_by_zero` pulses.
  - latency is the same as a normal divide.
- MTHI/MTLO:
  - register written on the accepting edge; FSM stays in IDLE, `busy` stays 0.
  - `done` pulses the following cycle.
- Reserved op: nothing is written, `illegal` pulses the next cycle.
- `start` while `busy`=1 is ignored; no queueing.
- HI/LO hold their value between operations.

## Timing
- Accept edge E0 (IDLE, `start`=1).
- `busy`=1 from E0 up to edge E0+WIDTH+1.
- At edge E0+WIDTH+1:
  - HI/LO are updated.
  - `busy` falls and `done`=1 for exactly one cycle.
  - Latency is WIDTH+1 cycles (33 at default).
- A new `start` may be presented in the same cycle `done`=1; it is accepted at the next edge (back-to-back).
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-CALC:
  - `busy` and `done` clear immediately; no `done` is produced.
  - HI/LO are 0 after reset.

## Configuration
- `MULDIV_DIV_EN`
  - Defined: DIV/DIVU supported as above.
  - Undefined: divide datapath omitted. Op 2/3 behaves as reserved: `illegal` pulses the next cycle, HI/LO unchanged, `busy` stays 0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 cycles after accept; `busy` high in between.
- MULT −3 (0xFFFFFFFD) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 ÷ 7 -> LO=14, HI=2.
- DIVU 0x1234 ÷ 0 -> LO=0xFFFFFFFF, HI=0x1234; `div_by_zero` and `done` pulse together.
- Simple-operation pulse timing:
  - MTHI 0xCAFE -> HI=0xCAFE the cycle after accept, `busy` never rises.
  - `start` pulsed mid-multiply -> ignored; result unchanged.
- Reset mid-op: assert `rst_n`=0 in CALC cycle 10 -> `busy`=0, HI=LO=0, no `done`. With `MULDIV_DIV_EN` undefined, DIV -> `illegal` pulse, HI/LO unchanged.
